// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-256 decryption datapath stages.
package aes_dec_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } imc_state_e;

   // Column 0 sits in the top 32 bits of the state, column 3 in the bottom.
   function automatic logic [COL_W-1:0] col_sel(input logic [STATE_W-1:0] state,
                                                input logic [1:0]         idx);
      return state[(STATE_W - COL_W) - COL_W * int'(idx) +: COL_W];
   endfunction

endpackage

// File: rtl/MixColumnHelper.sv
// Column unit: InvMixColumns of one 32-bit column, row 0 in [31:24].
module MixColumnHelper (
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] a   [4];
   logic [7:0] x2  [4];
   logic [7:0] x4  [4];
   logic [7:0] x8  [4];
   logic [7:0] m9  [4];
   logic [7:0] m11 [4];
   logic [7:0] m13 [4];
   logic [7:0] m14 [4];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Build the 9/11/13/14 multiples of every byte from a doubling chain, then mix.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         a[r]   = col_in[31 - 8*r -: 8];
         x2[r]  = xtime(a[r]);
         x4[r]  = xtime(x2[r]);
         x8[r]  = xtime(x4[r]);
         m9[r]  = x8[r] ^ a[r];
         m11[r] = x8[r] ^ x2[r] ^ a[r];
         m13[r] = x8[r] ^ x4[r] ^ a[r];
         m14[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      col_out = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                 m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                 m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                 m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
   end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns stage: accepts a state, transforms COLS_PER_CYC
// columns per cycle in place, then holds the result until downstream takes it.
module inv_mix_columns_seq #(
   parameter int COLS_PER_CYC = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_bypass,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   import aes_dec_pkg::*;

   if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYC must be 1, 2 or 4");
   end

   imc_state_e         state_q, state_d;
   logic [STATE_W-1:0] st_q, st_d;
   logic [STATE_W-1:0] out_state_q, out_state_d;
   logic [1:0]         col_q, col_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               in_ready_q, in_ready_d;

   logic [COL_W-1:0]   mix_in  [COLS_PER_CYC];
   logic [COL_W-1:0]   mix_out [COLS_PER_CYC];

   for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_mix
      assign mix_in[g] = col_sel(st_q, col_q + 2'(g));
      MixColumnHelper u_mix (
         .col_in  (mix_in[g]),
         .col_out (mix_out[g])
      );
   end

   // Ready is forced low while reset is held so nothing is accepted during reset.
   assign in_ready  = in_ready_q & rst_n;
   assign out_valid = out_valid_q;
   assign out_state = out_state_q;
   assign busy      = busy_q;

   // Next-state logic: accept, column-by-column transform, and output hold.
   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      out_state_d = out_state_q;
      col_d       = col_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      in_ready_d  = in_ready_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               st_d       = in_state;
               col_d      = '0;
               busy_d     = 1'b1;
               in_ready_d = 1'b0;
               if (in_bypass) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_state_d = in_state;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            for (int g = 0; g < COLS_PER_CYC; g++) begin
               st_d[(STATE_W - COL_W) - COL_W * (int'(col_q) + g) +: COL_W] = mix_out[g];
            end
            col_d = col_q + 2'(COLS_PER_CYC);
            if (int'(col_q) + COLS_PER_CYC == 4) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_state_d = st_d;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State register; reset discards any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         st_q        <= '0;
         out_state_q <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         out_state_q <= out_state_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq at COLS_PER_CYC = 1, 2 and 4.
module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [127:0] in_state;
   logic         in_bypass;
   logic         out_ready;

   logic         in_ready1, out_valid1, busy1;
   logic [127:0] out_state1;
   logic         in_ready2, out_valid2, busy2;
   logic [127:0] out_state2;
   logic         in_ready4, out_valid4, busy4;
   logic [127:0] out_state4;

   int compared = 0;
   int failed   = 0;
   int cyc      = 0;

   logic [127:0] got_q [$];

   localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [127:0] C6_VEC   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

   inv_mix_columns_seq #(.COLS_PER_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid1),
      .out_ready(out_ready), .out_state(out_state1), .busy(busy1));

   inv_mix_columns_seq #(.COLS_PER_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid2),
      .out_ready(out_ready), .out_state(out_state2), .busy(busy2));

   inv_mix_columns_seq #(.COLS_PER_CYC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid4),
      .out_ready(out_ready), .out_state(out_state4), .busy(busy4));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every completed output transfer of the COLS_PER_CYC=1 instance.
   always @(negedge clk) begin
      if (rst_n && out_valid1 && out_ready) got_q.push_back(out_state1);
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] invMixModel(input logic [127:0] s);
      logic [127:0] res = '0;
      logic [7:0]   b [4];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) b[r] = s[127 - 32*c - 8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            res[127 - 32*c - 8*r -: 8] = gmul(b[r], 8'd14) ^ gmul(b[(r+1)%4], 8'd11)
                                       ^ gmul(b[(r+2)%4], 8'd13) ^ gmul(b[(r+3)%4], 8'd9);
         end
      end
      return res;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compared++;
      assert (observed === expected) else begin
         failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one state and wait (bounded) for dut1 to take it; returns the accept cycle.
   task automatic applyStimulus(input logic [127:0] st, input logic byp, output int acc_cyc);
      logic accepted = 1'b0;
      acc_cyc   = -1;
      in_state  = st;
      in_bypass = byp;
      in_valid  = 1'b1;
      for (int i = 0; i < 30 && !accepted; i++) begin
         if (in_ready1) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (accepted) acc_cyc = cyc;
      checkOutput("accept", {127'd0, accepted}, 128'd1);
   endtask

   initial begin
      int acc;
      int lat1, lat2, lat4;
      int acc_list [8];
      logic [127:0] stim [8];
      logic seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      in_bypass = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready_low", {127'd0, in_ready1}, 128'd0);
      checkOutput("rst_out_valid", {127'd0, out_valid1}, 128'd0);
      checkOutput("rst_out_state", out_state1, 128'd0);
      checkOutput("rst_busy", {127'd0, busy1}, 128'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready", {127'd0, in_ready1}, 128'd1);
      checkOutput("rel_busy", {127'd0, busy1}, 128'd0);

      // FIPS vector on all three widths, latency sweep
      $display("[TB] FIPS-197 vector, latency sweep");
      applyStimulus(FIPS_IN, 1'b0, acc);
      checkOutput("busy_after_accept", {127'd0, busy1}, 128'd1);
      checkOutput("in_ready_in_busy", {127'd0, in_ready1}, 128'd0);
      lat1 = 0; lat2 = 0; lat4 = 0;
      for (int k = 1; k <= 12; k++) begin
         if (lat1 == 0 && out_valid1) lat1 = k;
         if (lat2 == 0 && out_valid2) lat2 = k;
         if (lat4 == 0 && out_valid4) lat4 = k;
         if (lat1 != 0 && lat2 != 0 && lat4 != 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("latency_c1", 128'(lat1), 128'd5);
      checkOutput("latency_c2", 128'(lat2), 128'd3);
      checkOutput("latency_c4", 128'(lat4), 128'd2);
      checkOutput("fips_c1", out_state1, FIPS_OUT);
      checkOutput("fips_c2", out_state2, FIPS_OUT);
      checkOutput("fips_c4", out_state4, FIPS_OUT);

      // Backpressure: hold in DONE for 10 cycles while offering other data
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_state = {4{32'hffff_0000}} ^ 128'(i);
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", {127'd0, out_valid1}, 128'd1);
         checkOutput("bp_out_state", out_state1, FIPS_OUT);
         checkOutput("bp_in_ready", {127'd0, in_ready1}, 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("release_out_valid", {127'd0, out_valid1}, 128'd0);
      checkOutput("release_in_ready", {127'd0, in_ready1}, 128'd1);
      checkOutput("idle_out_state_hold", out_state1, FIPS_OUT);

      // Bypass: untouched state after one cycle
      $display("[TB] bypass");
      applyStimulus(FIPS_IN, 1'b1, acc);
      checkOutput("bypass_valid_lat1", {127'd0, out_valid1}, 128'd1);
      checkOutput("bypass_state", out_state1, FIPS_IN);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset on the second BUSY cycle
      $display("[TB] reset mid-BUSY");
      applyStimulus(FIPS_IN, 1'b0, acc);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", {127'd0, out_valid1}, 128'd0);
      checkOutput("abort_in_ready", {127'd0, in_ready1}, 128'd0);
      checkOutput("abort_out_state", out_state1, 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("abort_rel_in_ready", {127'd0, in_ready1}, 128'd1);
      applyStimulus(C6_VEC, 1'b0, acc);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (out_valid1) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("c6_valid", {127'd0, seen}, 128'd1);
      checkOutput("c6_state", out_state1, C6_VEC);
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back streaming of random states with out_ready held high
      $display("[TB] streaming");
      got_q.delete();
      for (int n = 0; n < 8; n++) begin
         stim[n] = {$urandom(), $urandom(), $urandom(), $urandom()};
         applyStimulus(stim[n], 1'b0, acc_list[n]);
      end
      for (int k = 0; k < 40 && got_q.size() < 8; k++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("stream_count", 128'(got_q.size()), 128'd8);
      for (int n = 0; n < 8; n++) begin
         if (n < got_q.size()) checkOutput("stream_data", got_q[n], invMixModel(stim[n]));
         if (n > 0) checkOutput("stream_spacing", 128'(acc_list[n] - acc_list[n-1]), 128'd6);
      end
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
